// File: rtl/pia_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// pia_bus_arbiter_if
//
// Bundles the three buses that meet at the PIA register-bus arbiter:
//   cpu_*  : 6502-side access (strobe/we/adr/wdata in, rdata/RDY out)
//   host_* : debug-host access (req/we/adr/wdata in, gnt/ack/rdata out)
//   pia_*  : the shared PIA register bus (stb/we/adr/wdata out, rdata in)
//
// Signal suffixes (_i/_o) are relative to the arbiter.
//
// Modports:
//   slave  : the arbiter's view (takes requests, drives the PIA bus)
//   master : the surrounding system's view (CPU decoder, host port, PIA)
// ---------------------------------------------------------------------------
interface pia_bus_arbiter_if;

  // CPU side
  logic       cpu_stb_i;
  logic       cpu_we_i;
  logic [6:0] cpu_adr_i;
  logic [7:0] cpu_dat_i;
  logic [7:0] cpu_dat_o;
  logic       cpu_rdy_o;

  // Host debug side
  logic       host_req_i;
  logic       host_we_i;
  logic [6:0] host_adr_i;
  logic [7:0] host_dat_i;
  logic       host_gnt_o;
  logic       host_ack_o;
  logic [7:0] host_dat_o;

  // Shared PIA bus
  logic       pia_stb_o;
  logic       pia_we_o;
  logic [6:0] pia_adr_o;
  logic [7:0] pia_dat_o;
  logic [7:0] pia_dat_i;

  modport slave (
    input  cpu_stb_i, cpu_we_i, cpu_adr_i, cpu_dat_i,
    output cpu_dat_o, cpu_rdy_o,
    input  host_req_i, host_we_i, host_adr_i, host_dat_i,
    output host_gnt_o, host_ack_o, host_dat_o,
    output pia_stb_o, pia_we_o, pia_adr_o, pia_dat_o,
    input  pia_dat_i
  );

  modport master (
    output cpu_stb_i, cpu_we_i, cpu_adr_i, cpu_dat_i,
    input  cpu_dat_o, cpu_rdy_o,
    output host_req_i, host_we_i, host_adr_i, host_dat_i,
    input  host_gnt_o, host_ack_o, host_dat_o,
    input  pia_stb_o, pia_we_o, pia_adr_o, pia_dat_o,
    output pia_dat_i
  );

endinterface

// File: rtl/pia_bus_arbiter.sv
// ---------------------------------------------------------------------------
// pia_bus_arbiter
//
// Shares the PIA register bus between the 6502 CPU and a host debug port.
// The CPU has fixed priority and sees zero added latency: its strobe is
// passed straight through to the PIA and cpu_dat_o is the raw PIA read data.
// The host gets the bus in any IDLE cycle the CPU leaves free. With the
// starvation guard built in, a host request that has lost MAX_WAIT IDLE
// cycles to the CPU is forced through, stalling the CPU for one cycle via RDY.
//
// Build option:
//   PIA_ARB_STARVE_EN  defined   -> wait counter + starvation guard present
//                      undefined -> strict CPU priority, cpu_rdy_o == 1,
//                                   MAX_WAIT ignored
//
// Parameters:
//   MAX_WAIT  IDLE cycles a pending host request may lose (1..255)
//
// Ports:
//   clk_i    system clock, rising edge
//   rst_ni   asynchronous active-low reset
//   bus      pia_bus_arbiter_if.slave (cpu_*, host_*, pia_* signals)
//
// Host transaction timing (gnt in cycle n):
//   write : ack in n+1
//   read  : pia_dat_i captured at end of n+1, ack + data in n+2
// ---------------------------------------------------------------------------
module pia_bus_arbiter #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  pia_bus_arbiter_if.slave      bus
);

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("pia_bus_arbiter: MAX_WAIT must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       host_win;
  logic       starve;
  logic [7:0] host_rdata;

  // -------------------------------------------------------------------------
  // Starvation guard
  // -------------------------------------------------------------------------
`ifdef PIA_ARB_STARVE_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;

  assign starve = (wait_cnt == WAIT_LIMIT);

  // Counts IDLE cycles a pending request loses to the CPU. Once it reaches
  // the limit it holds there (starve=1) until the forced grant clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt <= '0;
    end else if (!bus.host_req_i || host_win) begin
      wait_cnt <= '0;
    end else if (state == IDLE && !starve) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Arbitration, bus mux and next state
  // -------------------------------------------------------------------------
  // host_win is qualified with rst_ni so the PIA strobe and grant stay low
  // and RDY stays high for as long as reset is held.
  always_comb begin
    host_win       = rst_ni && (state == IDLE) && bus.host_req_i &&
                     (!bus.cpu_stb_i || starve);

    bus.pia_stb_o  = rst_ni && bus.cpu_stb_i;
    bus.pia_we_o   = bus.cpu_we_i;
    bus.pia_adr_o  = bus.cpu_adr_i;
    bus.pia_dat_o  = bus.cpu_dat_i;
    bus.host_gnt_o = 1'b0;
    state_next     = state;

    if (host_win) begin
      bus.pia_stb_o  = 1'b1;
      bus.pia_we_o   = bus.host_we_i;
      bus.pia_adr_o  = bus.host_adr_i;
      bus.pia_dat_o  = bus.host_dat_i;
      bus.host_gnt_o = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (host_win) begin
          state_next = bus.host_we_i ? ACK : CAPT;
        end
      end
      CAPT:    state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef PIA_ARB_STARVE_EN
  assign bus.cpu_rdy_o = !host_win;
`else
  // Host can only win when the CPU is not strobing, so RDY never drops.
  assign bus.cpu_rdy_o = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // Host read data capture
  // -------------------------------------------------------------------------
  // The PIA registers its read data, so the value for a read granted in
  // IDLE is on pia_dat_i during the following CAPT cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      host_rdata <= '0;
    end else if (state == CAPT) begin
      host_rdata <= bus.pia_dat_i;
    end
  end

  assign bus.host_dat_o = host_rdata;
  assign bus.host_ack_o = (state == ACK);
  assign bus.cpu_dat_o  = bus.pia_dat_i;

endmodule

// File: tb/tb_pia_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pia_bus_arbiter
//
// Directed bench for pia_bus_arbiter (MAX_WAIT=4). Includes a small PIA
// register-file model with registered read data. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pia_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  pia_bus_arbiter_if bus ();

  pia_bus_arbiter #(.MAX_WAIT(4)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // PIA model: register file with one-cycle registered read data.
  logic [7:0] pia_mem [128];
  logic [7:0] pia_rdata = 8'h00;

  always @(posedge clk) begin
    if (bus.pia_stb_o) begin
      if (bus.pia_we_o) pia_mem[bus.pia_adr_o] <= bus.pia_dat_o;
      else              pia_rdata <= pia_mem[bus.pia_adr_o];
    end
  end

  assign bus.pia_dat_i = pia_rdata;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic cpu_drive(input logic stb, input logic we,
                           input logic [6:0] adr, input logic [7:0] dat);
    bus.cpu_stb_i = stb;
    bus.cpu_we_i  = we;
    bus.cpu_adr_i = adr;
    bus.cpu_dat_i = dat;
  endtask

  task automatic host_drive(input logic req, input logic we,
                            input logic [6:0] adr, input logic [7:0] dat);
    bus.host_req_i = req;
    bus.host_we_i  = we;
    bus.host_adr_i = adr;
    bus.host_dat_i = dat;
  endtask

  initial begin
    int unsigned gnt_seen;
    int unsigned rdy_low;

    for (int i = 0; i < 128; i++) pia_mem[i] = 8'h00;
    pia_mem[2] = 8'h33;
    pia_mem[4] = 8'h5A;

    // ---------------- Reset with both requesters active ----------------
    rst_n = 1'b0;
    cpu_drive(1'b1, 1'b1, 7'h10, 8'hEE);
    host_drive(1'b1, 1'b1, 7'h11, 8'hDD);
    mid();
    tick();
    mid();
    check("rst_pia_stb", 32'(bus.pia_stb_o), 32'h0);
    check("rst_cpu_rdy", 32'(bus.cpu_rdy_o), 32'h1);
    check("rst_gnt", 32'(bus.host_gnt_o), 32'h0);
    check("rst_ack", 32'(bus.host_ack_o), 32'h0);
    check("rst_host_dat", 32'(bus.host_dat_o), 32'h00);
    tick();
    rst_n = 1'b1;
    cpu_drive(1'b0, 1'b0, 7'h00, 8'h00);
    host_drive(1'b0, 1'b0, 7'h00, 8'h00);
    tick();
    check("rst_no_write", 32'(pia_mem[7'h10]), 32'h00);

    // ---------------- Host write, CPU idle, back-to-back ----------------
    host_drive(1'b1, 1'b1, 7'h03, 8'h80);               // cycle n
    mid();
    check("wr_gnt", 32'(bus.host_gnt_o), 32'h1);
    check("wr_pia_stb", 32'(bus.pia_stb_o), 32'h1);
    check("wr_pia_we", 32'(bus.pia_we_o), 32'h1);
    check("wr_pia_adr", 32'(bus.pia_adr_o), 32'h03);
    check("wr_pia_dat", 32'(bus.pia_dat_o), 32'h80);
    tick();
    host_drive(1'b1, 1'b1, 7'h05, 8'h11);               // n+1: ACK, req ignored
    mid();
    check("wr_ack", 32'(bus.host_ack_o), 32'h1);
    check("wr_ack_no_gnt", 32'(bus.host_gnt_o), 32'h0);
    tick();                                             // n+2: second grant
    mid();
    check("wr2_gnt", 32'(bus.host_gnt_o), 32'h1);
    check("wr2_pia_adr", 32'(bus.pia_adr_o), 32'h05);
    check("wr2_ack_low", 32'(bus.host_ack_o), 32'h0);
    tick();
    host_drive(1'b0, 1'b0, 7'h00, 8'h00);
    mid();
    check("wr2_ack", 32'(bus.host_ack_o), 32'h1);
    tick();
    cpu_drive(1'b1, 1'b0, 7'h03, 8'h00);                // CPU reads 0x03
    mid();
    check("cpu_rd_stb", 32'(bus.pia_stb_o), 32'h1);
    check("cpu_rd_adr", 32'(bus.pia_adr_o), 32'h03);
    check("cpu_rd_rdy", 32'(bus.cpu_rdy_o), 32'h1);
    tick();
    cpu_drive(1'b0, 1'b0, 7'h00, 8'h00);
    mid();
    check("cpu_rd_dat", 32'(bus.cpu_dat_o), 32'h80);
    check("mem_05", 32'(pia_mem[7'h05]), 32'h11);
    tick();

    // ---------------- Host read with CPU read in n+1 ----------------
    host_drive(1'b1, 1'b0, 7'h04, 8'h00);               // cycle n
    mid();
    check("rd_gnt", 32'(bus.host_gnt_o), 32'h1);
    check("rd_pia_we", 32'(bus.pia_we_o), 32'h0);
    check("rd_pia_adr", 32'(bus.pia_adr_o), 32'h04);
    tick();
    host_drive(1'b0, 1'b0, 7'h00, 8'h00);               // n+1: CAPT
    cpu_drive(1'b1, 1'b0, 7'h02, 8'h00);
    mid();
    check("rd_capt_no_ack", 32'(bus.host_ack_o), 32'h0);
    check("rd_capt_cpu_adr", 32'(bus.pia_adr_o), 32'h02);
    check("rd_capt_rdy", 32'(bus.cpu_rdy_o), 32'h1);
    tick();
    cpu_drive(1'b0, 1'b0, 7'h00, 8'h00);                // n+2: ACK
    mid();
    check("rd_ack", 32'(bus.host_ack_o), 32'h1);
    check("rd_host_dat", 32'(bus.host_dat_o), 32'h5A);
    check("rd_cpu_dat", 32'(bus.cpu_dat_o), 32'h33);
    tick();
    mid();
    check("rd_ack_pulse", 32'(bus.host_ack_o), 32'h0);
    check("rd_host_dat_hold", 32'(bus.host_dat_o), 32'h5A);
    tick();

    // ---------------- Contention: CPU strobes every cycle ----------------
    cpu_drive(1'b1, 1'b0, 7'h00, 8'h00);
    host_drive(1'b1, 1'b1, 7'h06, 8'h22);
`ifdef PIA_ARB_STARVE_EN
    for (int c = 0; c < 4; c++) begin                   // cycles 0..3: CPU wins
      mid();
      check($sformatf("starve_c%0d_gnt", c), 32'(bus.host_gnt_o), 32'h0);
      check($sformatf("starve_c%0d_rdy", c), 32'(bus.cpu_rdy_o), 32'h1);
      tick();
    end
    mid();                                              // cycle 4: forced
    check("starve_c4_gnt", 32'(bus.host_gnt_o), 32'h1);
    check("starve_c4_rdy", 32'(bus.cpu_rdy_o), 32'h0);
    check("starve_c4_adr", 32'(bus.pia_adr_o), 32'h06);
    check("starve_c4_dat", 32'(bus.pia_dat_o), 32'h22);
    tick();
    host_drive(1'b0, 1'b0, 7'h00, 8'h00);
    mid();
    check("starve_c5_rdy", 32'(bus.cpu_rdy_o), 32'h1);
    check("starve_c5_ack", 32'(bus.host_ack_o), 32'h1);
    tick();
    mid();
    check("starve_c6_rdy", 32'(bus.cpu_rdy_o), 32'h1);
    check("starve_c6_gnt", 32'(bus.host_gnt_o), 32'h0);
    tick();
    cpu_drive(1'b0, 1'b0, 7'h00, 8'h00);
`else
    gnt_seen = 0;
    rdy_low  = 0;
    for (int c = 0; c < 1000; c++) begin
      mid();
      if (bus.host_gnt_o) gnt_seen++;
      if (!bus.cpu_rdy_o) rdy_low++;
      tick();
    end
    check("strict_no_gnt", gnt_seen, 32'd0);
    check("strict_rdy_high", rdy_low, 32'd0);
    cpu_drive(1'b0, 1'b0, 7'h00, 8'h00);
    mid();
    check("strict_gnt_free", 32'(bus.host_gnt_o), 32'h1);
    check("strict_free_adr", 32'(bus.pia_adr_o), 32'h06);
    check("strict_free_rdy", 32'(bus.cpu_rdy_o), 32'h1);
    tick();
    host_drive(1'b0, 1'b0, 7'h00, 8'h00);
    mid();
    check("strict_ack", 32'(bus.host_ack_o), 32'h1);
    tick();
`endif
    tick();
    check("mem_06", 32'(pia_mem[7'h06]), 32'h22);

    // ---------------- Reset during CAPT ----------------
    host_drive(1'b1, 1'b0, 7'h04, 8'h00);               // cycle n: gnt
    mid();
    check("rcapt_gnt", 32'(bus.host_gnt_o), 32'h1);
    tick();
    host_drive(1'b0, 1'b0, 7'h00, 8'h00);               // n+1: CAPT, then reset
    rst_n = 1'b0;
    mid();
    check("rcapt_ack_in_rst", 32'(bus.host_ack_o), 32'h0);
    check("rcapt_dat_in_rst", 32'(bus.host_dat_o), 32'h00);
    tick();
    rst_n = 1'b1;
    mid();
    check("rcapt_no_ack", 32'(bus.host_ack_o), 32'h0);
    tick();
    mid();
    check("rcapt_no_ack2", 32'(bus.host_ack_o), 32'h0);
    check("rcapt_dat_clr", 32'(bus.host_dat_o), 32'h00);
    tick();
    host_drive(1'b1, 1'b0, 7'h02, 8'h00);               // re-request: read 0x02
    mid();
    check("rreq_gnt", 32'(bus.host_gnt_o), 32'h1);
    tick();
    host_drive(1'b0, 1'b0, 7'h00, 8'h00);
    mid();
    check("rreq_capt_no_ack", 32'(bus.host_ack_o), 32'h0);
    tick();
    mid();
    check("rreq_ack", 32'(bus.host_ack_o), 32'h1);
    check("rreq_dat", 32'(bus.host_dat_o), 32'h33);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pia_bus_arbiter.md
# pia_bus_arbiter

Shares the PIA register bus (strobe/write/7-bit address/8-bit data) between the 6502 CPU and a host debug port. The host port is used for switch injection, timer inspection and save-state readback. The CPU has fixed priority and sees zero added latency. A bounded-wait guard stalls the CPU through RDY so that host accesses cannot starve. The block sits between the CPU bus decoder and the PIA instance.

## Interface
Parameters:
- MAX_WAIT, default 16: number of IDLE cycles a pending host request may lose to the CPU before it is forced through. Legal range 1..255.

Ports:
- clk_i  in  1  system clock; all state updates on the rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- cpu_stb_i  in  1  CPU access strobe for the PIA address range
- cpu_we_i  in  1  CPU write (1) / read (0)
- cpu_adr_i  in  7  CPU register address
- cpu_dat_i  in  8  CPU write data
- cpu_dat_o  out  8  CPU read data; equals pia_dat_i
- cpu_rdy_o  out  1  CPU RDY; 0 means the CPU access is stalled
- host_req_i  in  1  host request; held high until host_gnt_o
- host_we_i  in  1  host write (1) / read (0)
- host_adr_i  in  7  host register address
- host_dat_i  in  8  host write data
- host_gnt_o  out  1  host access placed on the PIA bus this cycle
- host_ack_o  out  1  one-cycle completion pulse
- host_dat_o  out  8  host read data; valid while host_ack_o=1 and held until the next host read
- pia_stb_o, pia_we_o, pia_adr_o[6:0], pia_dat_o[7:0]  out  PIA bus
- pia_dat_i  in  8  PIA read data; registered in the PIA, valid the cycle after the read strobe

## Operation
- State machine states: IDLE, CAPT, ACK. Reset state is IDLE.
- host_win in IDLE is true when host_req_i=1 and either (cpu_stb_i=0 or starve=1). host_win is always false in CAPT and ACK.
- Bus mux (combinational):
  - host_win=1: pia_* is driven from host_*, host_gnt_o=1, cpu_rdy_o=0.
  - otherwise: pia_* is driven from cpu_*, pia_stb_o=cpu_stb_i, cpu_rdy_o=1.
- When the CPU is stalled, it holds its strobe, address and data. The arbiter does not buffer CPU requests.
- IDLE transitions:
  - host_win with a write goes to ACK.
  - host_win with a read goes to CAPT.
  - otherwise stay in IDLE.
- CAPT: capture pia_dat_i into host_dat_o, go to ACK. The CPU owns the bus in this cycle.
- ACK: host_ack_o=1, go to IDLE. The CPU owns the bus. host_req_i is ignored in this cycle.
- Wait counter (8 bits):
  - Increments each IDLE cycle in which host_req_i=1 and the host is not granted.
  - Clears on grant, or when host_req_i=0.
  - Saturates at MAX_WAIT.
  - starve = (wait_cnt == MAX_WAIT).
- cpu_dat_o = pia_dat_i unconditionally. A host read issued no earlier than the cycle after a CPU read cannot corrupt the CPU sample.

## Timing
- CPU path: zero added latency. A strobe in cycle n reaches the PIA in cycle n, and read data appears on cpu_dat_o in cycle n+1.
- Host write: gnt in cycle n, ack in cycle n+1.
- Host read: gnt in cycle n, capture at the end of n+1, ack with data in cycle n+2.
- Minimum spacing between host grants is 2 cycles for writes and 3 cycles for reads.
- Worst-case host grant latency under continuous CPU strobing is MAX_WAIT+1 IDLE cycles after the request.
- Simultaneous CPU strobe and host request with starve=0: CPU wins and the counter increments.
- Simultaneous CPU strobe and host request with starve=1: host wins and the CPU is stalled exactly one cycle.
- Reset values, and values while rst_ni=0:
  - state IDLE, wait_cnt 0, host_dat_o 0x00
  - host_gnt_o 0, host_ack_o 0, pia_stb_o 0, cpu_rdy_o 1
- Reset asserted mid-transaction: the transaction is dropped and no ack is issued. The host must re-request.

## Configuration
- PIA_ARB_STARVE_EN defined: wait counter and starve logic are present as described above.
- PIA_ARB_STARVE_EN undefined:
  - starve is constant 0; the counter is removed and MAX_WAIT is ignored.
  - Strict CPU priority: cpu_rdy_o is constant 1, and the host waits indefinitely while cpu_stb_i=1.

## Test plan
- Reset: hold rst_ni=0 with cpu_stb_i=1 and host_req_i=1 -> pia_stb_o=0, cpu_rdy_o=1, host_gnt_o=0, host_dat_o=0x00.
- Host write with CPU idle: host writes 0x80 to 0x03 -> gnt with pia_adr_o=0x03 and pia_dat_o=0x80 in cycle n; host_ack_o in cycle n+1; 0x03 then reads back 0x80 via the CPU.
- Host read: host reads 0x04 with the PIA returning 0x5A -> ack in cycle n+2 with host_dat_o=0x5A. A CPU read of 0x02 in cycle n+1 gets its own data in cycle n+2.
- Contention, MAX_WAIT=4, starve enabled: CPU strobes every cycle and the host requests from cycle 0 -> host gnt in cycle 4, with cpu_rdy_o=0 only in cycle 4.
- Same contention with PIA_ARB_STARVE_EN undefined: no gnt for 1000 cycles; gnt the first cycle cpu_stb_i=0.
- Reset pulse in a CAPT cycle -> no host_ack_o, state IDLE; the next request completes normally.
